// File: rtl/regfile_writeback.sv
// Writeback sequencer: merges ALU and load results into an in-order FIFO,
// retires one register-file write per cycle and serialises environment calls.
module regfile_writeback #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alu_valid,
   input  logic [4:0]       alu_rd,
   input  logic [63:0]      alu_data,
   output logic             alu_ready,
   input  logic             mem_valid,
   input  logic [4:0]       mem_rd,
   input  logic [63:0]      mem_data,
   output logic             mem_ready,
   input  logic             ecall_req,
   output logic             ecall_ack,
   output logic             rf_write_enable,
   output logic [4:0]       rf_write_register,
   output logic [63:0]      rf_write_value,
   input  logic             rf_write_ready,
   output logic             rf_ecall,
   input  logic             rf_ecall_done,
   output logic [CNT_W-1:0] pending,
   output logic             busy
);

   // state   | meaning
   // S_IDLE  | accept results, retire writes, watch for ecall_req
   // S_DRAIN | intake blocked, retire until the FIFO is empty
   // S_CALL  | one-cycle rf_ecall pulse, no writes
   // S_WAIT  | wait for rf_ecall_done (no timeout)
   // S_ACK   | one-cycle ecall_ack pulse back to the pipeline
   typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_CALL, S_WAIT, S_ACK} state_t;

   localparam int PTR_W = $clog2(DEPTH);

   state_t state, state_nx;

   logic [4:0]       fifo_rd   [DEPTH];
   logic [63:0]      fifo_data [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;

   logic             is_idle, full, empty;
   logic             mem_xfer, alu_xfer, push, pop;
   logic [4:0]       in_rd;
   logic [63:0]      in_data;

   assign is_idle = (state == S_IDLE);
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);

   // Readiness looks only at the registered count, so a full FIFO refuses
   // a push even when the head pops in the same cycle.
   assign mem_ready = is_idle && !full;
   assign alu_ready = is_idle && !full && !mem_valid;

   assign mem_xfer = mem_valid && mem_ready;
   assign alu_xfer = alu_valid && alu_ready;
   assign in_rd    = mem_xfer ? mem_rd   : alu_rd;
   assign in_data  = mem_xfer ? mem_data : alu_data;
   assign push     = (mem_xfer || alu_xfer) && (in_rd != 5'd0);

   assign rf_write_enable   = !empty && (state == S_IDLE || state == S_DRAIN);
   assign rf_write_register = fifo_rd[head];
   assign rf_write_value    = fifo_data[head];
   assign pop               = rf_write_enable && rf_write_ready;

   assign rf_ecall  = (state == S_CALL);
   assign ecall_ack = (state == S_ACK);
   assign pending   = count;
   assign busy      = !is_idle || !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[tail]   <= in_rd;
         fifo_data[tail] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         state <= state_nx;
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (ecall_req) state_nx = S_DRAIN;
         S_DRAIN: if (empty || (count == CNT_W'(1) && pop)) state_nx = S_CALL;
         S_CALL:  state_nx = S_WAIT;
         S_WAIT:  if (rf_ecall_done) state_nx = S_ACK;
         S_ACK:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_writeback;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             alu_valid, mem_valid;
   logic [4:0]       alu_rd, mem_rd;
   logic [63:0]      alu_data, mem_data;
   logic             alu_ready, mem_ready;
   logic             ecall_req, ecall_ack;
   logic             rf_write_enable;
   logic [4:0]       rf_write_register;
   logic [63:0]      rf_write_value;
   logic             rf_write_ready;
   logic             rf_ecall, rf_ecall_done;
   logic [CNT_W-1:0] pending;
   logic             busy;

   regfile_writeback #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .ecall_req(ecall_req), .ecall_ack(ecall_ack),
      .rf_write_enable(rf_write_enable), .rf_write_register(rf_write_register),
      .rf_write_value(rf_write_value), .rf_write_ready(rf_write_ready),
      .rf_ecall(rf_ecall), .rf_ecall_done(rf_ecall_done),
      .pending(pending), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: ordered list of outstanding writes plus the ecall phase.
   typedef struct packed { logic [4:0] rd; logic [63:0] data; } entry_t;
   localparam int P_IDLE = 0, P_DRAIN = 1, P_CALL = 2, P_WAIT = 3, P_ACK = 4;
   entry_t q[$];
   int     m_phase = P_IDLE;
   bit     m_valid = 0;

   always @(negedge clk) begin
      bit     e_mem_rdy, e_alu_rdy, e_we, acc_mem, acc_alu;
      entry_t e;
      e_mem_rdy = (m_phase == P_IDLE) && (q.size() < DEPTH);
      e_alu_rdy = e_mem_rdy && !mem_valid;
      e_we      = (q.size() > 0) && (m_phase == P_IDLE || m_phase == P_DRAIN);
      if (m_valid) begin
         chk("mem_ready", 64'(mem_ready), 64'(e_mem_rdy));
         chk("alu_ready", 64'(alu_ready), 64'(e_alu_rdy));
         chk("rf_write_enable", 64'(rf_write_enable), 64'(e_we));
         if (e_we) begin
            chk("rf_write_register", 64'(rf_write_register), 64'(q[0].rd));
            chk("rf_write_value", rf_write_value, q[0].data);
         end
         chk("rf_ecall", 64'(rf_ecall), 64'(m_phase == P_CALL));
         chk("ecall_ack", 64'(ecall_ack), 64'(m_phase == P_ACK));
         chk("pending", 64'(pending), 64'(q.size()));
         chk("busy", 64'(busy), 64'(m_phase != P_IDLE || q.size() != 0));
      end
      if (reset) begin
         q.delete();
         m_phase = P_IDLE;
         m_valid = 1;
      end else if (m_valid) begin
         acc_mem = mem_valid && e_mem_rdy;
         acc_alu = alu_valid && e_alu_rdy;
         if (e_we && rf_write_ready) void'(q.pop_front());
         if (acc_mem && mem_rd != 0) begin e.rd = mem_rd; e.data = mem_data; q.push_back(e); end
         else if (acc_alu && alu_rd != 0) begin e.rd = alu_rd; e.data = alu_data; q.push_back(e); end
         case (m_phase)
            P_IDLE:  if (ecall_req) m_phase = P_DRAIN;
            P_DRAIN: if (q.size() == 0) m_phase = P_CALL;
            P_CALL:  m_phase = P_WAIT;
            P_WAIT:  if (rf_ecall_done) m_phase = P_ACK;
            default: m_phase = P_IDLE;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_push(input logic [4:0] rd, input logic [63:0] d);
      alu_valid = 1; alu_rd = rd; alu_data = d;
      step();
      alu_valid = 0;
   endtask

   initial begin
      bit ackd;
      reset = 1; alu_valid = 0; mem_valid = 0; alu_rd = 0; mem_rd = 0;
      alu_data = 0; mem_data = 0; ecall_req = 0; rf_write_ready = 1; rf_ecall_done = 0;
      step(); step();
      reset = 0;
      @(negedge clk);
      chk("reset pending", 64'(pending), 64'd0);
      chk("reset we", 64'(rf_write_enable), 64'd0);
      chk("reset rf_ecall", 64'(rf_ecall), 64'd0);
      chk("reset ack", 64'(ecall_ack), 64'd0);

      // single ALU write to x5
      step();
      alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
      @(negedge clk);
      chk("x5 alu_ready", 64'(alu_ready), 64'd1);
      step(); alu_valid = 0;
      @(negedge clk);
      chk("x5 we", 64'(rf_write_enable), 64'd1);
      chk("x5 reg", 64'(rf_write_register), 64'd5);
      chk("x5 val", rf_write_value, 64'h1234);
      chk("x5 pending1", 64'(pending), 64'd1);
      step();
      @(negedge clk);
      chk("x5 pending0", 64'(pending), 64'd0);

      // load unit has priority
      step();
      rf_write_ready = 0;
      mem_valid = 1; mem_rd = 3; mem_data = 64'h33;
      alu_valid = 1; alu_rd = 4; alu_data = 64'h44;
      @(negedge clk);
      chk("prio mem_ready", 64'(mem_ready), 64'd1);
      chk("prio alu_ready", 64'(alu_ready), 64'd0);
      step(); mem_valid = 0;
      @(negedge clk);
      chk("prio alu_ready2", 64'(alu_ready), 64'd1);
      chk("prio head x3", 64'(rf_write_register), 64'd3);
      step(); alu_valid = 0; rf_write_ready = 1;
      @(negedge clk);
      chk("prio pending2", 64'(pending), 64'd2);
      step();
      @(negedge clk);
      chk("prio head x4", 64'(rf_write_register), 64'd4);
      chk("prio val x4", rf_write_value, 64'h44);
      step(); step();

      // fill to DEPTH with the register file stalled
      rf_write_ready = 0;
      for (int i = 0; i < DEPTH; i++) alu_push(5'(10 + i), 64'(100 + i));
      alu_valid = 1; alu_rd = 14; alu_data = 64'd104;
      @(negedge clk);
      chk("full pending", 64'(pending), 64'(DEPTH));
      chk("full alu_ready", 64'(alu_ready), 64'd0);
      step(); rf_write_ready = 1;
      @(negedge clk);
      chk("full refuse", 64'(alu_ready), 64'd0);
      chk("full head", 64'(rf_write_register), 64'd10);
      step();
      @(negedge clk);
      chk("freed alu_ready", 64'(alu_ready), 64'd1);
      chk("freed head", 64'(rf_write_register), 64'd11);
      step(); alu_valid = 0;
      @(negedge clk);
      chk("push+pop pending", 64'(pending), 64'd3);
      repeat (4) step();

      // write to x0 is consumed only
      alu_valid = 1; alu_rd = 0; alu_data = 64'hFFFF;
      @(negedge clk);
      chk("x0 alu_ready", 64'(alu_ready), 64'd1);
      step(); alu_valid = 0;
      @(negedge clk);
      chk("x0 pending", 64'(pending), 64'd0);
      chk("x0 we", 64'(rf_write_enable), 64'd0);

      // ecall with three writes pending
      step();
      rf_write_ready = 0;
      for (int i = 0; i < 3; i++) alu_push(5'(20 + i), 64'(200 + i));
      ecall_req = 1; rf_write_ready = 1;
      @(negedge clk);
      chk("ec c0 reg", 64'(rf_write_register), 64'd20);
      step();
      alu_valid = 1; alu_rd = 9; alu_data = 64'h99;
      @(negedge clk);
      chk("ec drain mem_ready", 64'(mem_ready), 64'd0);
      chk("ec drain alu_ready", 64'(alu_ready), 64'd0);
      chk("ec c1 reg", 64'(rf_write_register), 64'd21);
      step();
      @(negedge clk);
      chk("ec c2 reg", 64'(rf_write_register), 64'd22);
      step();
      @(negedge clk);
      chk("ec call pulse", 64'(rf_ecall), 64'd1);
      chk("ec call we", 64'(rf_write_enable), 64'd0);
      step(); rf_ecall_done = 1;
      @(negedge clk);
      chk("ec wait rf_ecall", 64'(rf_ecall), 64'd0);
      chk("ec wait alu_ready", 64'(alu_ready), 64'd0);
      step(); rf_ecall_done = 0;
      @(negedge clk);
      chk("ec ack", 64'(ecall_ack), 64'd1);
      step(); ecall_req = 0; alu_valid = 0;
      @(negedge clk);
      chk("ec ack done", 64'(ecall_ack), 64'd0);
      chk("ec idle busy", 64'(busy), 64'd0);

      // reset while draining with two entries queued
      step();
      rf_write_ready = 0;
      alu_push(5'd7, 64'h7); alu_push(5'd8, 64'h8);
      ecall_req = 1;
      step();
      @(negedge clk);
      chk("rst drain mem_ready", 64'(mem_ready), 64'd0);
      reset = 1; ecall_req = 0;
      step(); reset = 0;
      @(negedge clk);
      chk("rst drain pending", 64'(pending), 64'd0);
      chk("rst drain we", 64'(rf_write_enable), 64'd0);
      chk("rst drain mem_ready2", 64'(mem_ready), 64'd1);

      // reset while waiting for rf_ecall_done
      step();
      rf_write_ready = 1; ecall_req = 1;
      step(); step();
      @(negedge clk);
      chk("rst wait call", 64'(rf_ecall), 64'd1);
      step();
      reset = 1; ecall_req = 0;
      step(); reset = 0;
      @(negedge clk);
      chk("rst wait rf_ecall", 64'(rf_ecall), 64'd0);
      chk("rst wait ack", 64'(ecall_ack), 64'd0);
      chk("rst wait alu_ready", 64'(alu_ready), 64'd1);
      chk("rst wait busy", 64'(busy), 64'd0);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         ackd = ecall_ack;
         step();
         reset          = ($urandom_range(0, 299) == 0);
         alu_valid      = ($urandom_range(0, 99) < 55);
         mem_valid      = ($urandom_range(0, 99) < 35);
         alu_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         mem_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         alu_data       = {$urandom, $urandom};
         mem_data       = {$urandom, $urandom};
         rf_write_ready = ($urandom_range(0, 99) < 60);
         rf_ecall_done  = ($urandom_range(0, 99) < 25);
         if (reset || ackd) ecall_req = 0;
         else if (!ecall_req && $urandom_range(0, 99) < 4) ecall_req = 1;
      end
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
